// File: rtl/vga_vram_scaled.sv
// vga_vram_scaled: VGA scan-out of a magnified, scrollable byte VRAM with
// RGB332 or 16-entry palette colour, a CPU read/write port, a frame counter
// and a vblank-start pulse. Pipeline: S0 counters, S1 address, S2 VRAM data,
// S3 colour/sync; every output lags the counters by three clocks.
module vga_vram_scaled #(
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_SYNC_END   = 752,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_SYNC_END   = 492,
  parameter int unsigned SCALE_SHIFT  = 4,
  parameter int unsigned COLS_BITS    = 6,
  parameter int unsigned ROWS_BITS    = 6
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] data_length,
  input  logic [31:0] data_address,
  input  logic [7:0]  data_din,
  input  logic        data_we,
  input  logic        data_oe,
  output logic [7:0]  data_dout,
  output logic        data_valid,
  input  logic        palette_we,
  input  logic [3:0]  palette_index,
  input  logic [11:0] palette_din,
  input  logic        mode,
  input  logic [31:0] offset_h,
  input  logic [31:0] offset_v,
  output logic        vblank_start,
  output logic [15:0] frame_count,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int unsigned HW    = $clog2(H_TOTAL);
  localparam int unsigned VW    = $clog2(V_TOTAL);
  localparam int unsigned AW    = COLS_BITS + ROWS_BITS;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PXW   = COLS_BITS + SCALE_SHIFT;
  localparam int unsigned PYW   = ROWS_BITS + SCALE_SHIFT;

  // S0 raster counters and per-frame shadow state
  logic [HW-1:0]  count_h_q, count_h_d;
  logic [VW-1:0]  count_v_q, count_v_d;
  logic [PXW-1:0] off_h_s_q, off_h_s_d;
  logic [PYW-1:0] off_v_s_q, off_v_s_d;
  logic           vblank_q, vblank_d;
  logic [15:0]    frame_q, frame_d;

  // S1 viewport address and delayed timing flags
  logic [AW-1:0]  addr1_q, addr1_d;
  logic           active1_q, active1_d;
  logic           hs1_q, hs1_d;
  logic           vs1_q, vs1_d;

  // S2 VRAM cell and delayed timing flags
  logic [7:0]     cell2_q, cell2_d;
  logic           mode2_q, mode2_d;
  logic           active2_q, active2_d;
  logic           hs2_q, hs2_d;
  logic           vs2_q, vs2_d;

  // S3 pin registers
  logic [11:0]    rgb_q, rgb_d;
  logic           hs3_q, hs3_d;
  logic           vs3_q, vs3_d;

  // CPU port and palette
  logic [7:0]     dout_q, dout_d;
  logic           valid_q, valid_d;
  logic [11:0]    palette_q [16];
  logic [11:0]    palette_d [16];
  logic [7:0]     vram_mem [DEPTH];

  logic           latch_c;
  logic [PXW-1:0] px_c;
  logic [PYW-1:0] py_c;
  logic           in_range_c;
  logic [AW-1:0]  cpu_idx_c;
  logic [11:0]    pal_c;
  logic [11:0]    direct_c;
  logic           unused_c;

  // Only the low viewport bits of the scroll offsets matter (wrap-around)
  assign unused_c = ^{offset_h[31:PXW], offset_v[31:PYW]};

  // Shadow offsets, frame counter and vblank pulse share one trigger point
  assign latch_c = (count_h_q == '0) && (count_v_q == VW'(V_ACTIVE));

  // S0: raster counters, h wraps first and carries into v
  always_comb begin
    count_h_d = count_h_q + HW'(1);
    count_v_d = count_v_q;
    if (count_h_q == HW'(H_TOTAL - 1)) begin
      count_h_d = '0;
      count_v_d = (count_v_q == VW'(V_TOTAL - 1)) ? '0 : count_v_q + VW'(1);
    end
  end

  // Once-per-frame latch of scroll offsets, frame count and vblank pulse
  always_comb begin
    off_h_s_d = off_h_s_q;
    off_v_s_d = off_v_s_q;
    frame_d   = frame_q;
    vblank_d  = latch_c;
    if (latch_c) begin
      off_h_s_d = offset_h[PXW-1:0];
      off_v_s_d = offset_v[PYW-1:0];
      frame_d   = frame_q + 16'd1;
    end
  end

  // S1: scrolled viewport position and sync/active decode
  always_comb begin
    px_c      = PXW'(count_h_q) + off_h_s_q;
    py_c      = PYW'(count_v_q) + off_v_s_q;
    addr1_d   = {py_c[PYW-1:SCALE_SHIFT], px_c[PXW-1:SCALE_SHIFT]};
    active1_d = (count_h_q < HW'(H_ACTIVE)) && (count_v_q < VW'(V_ACTIVE));
    hs1_d     = !((count_h_q >= HW'(H_SYNC_START)) && (count_h_q < HW'(H_SYNC_END)));
    vs1_d     = !((count_v_q >= VW'(V_SYNC_START)) && (count_v_q < VW'(V_SYNC_END)));
  end

  // S2: display VRAM read; a same-cycle CPU write lands after this read
  always_comb begin
    cell2_d   = vram_mem[addr1_q];
    mode2_d   = mode;
    active2_d = active1_q;
    hs2_d     = hs1_q;
    vs2_d     = vs1_q;
  end

  // S3: colour expansion or palette lookup, blanked outside the active area
  always_comb begin
    pal_c    = palette_q[cell2_q[3:0]];
    direct_c = {cell2_q[7:5], cell2_q[7], cell2_q[4:2], cell2_q[4],
                cell2_q[1:0], cell2_q[1:0]};
    rgb_d    = '0;
    if (active2_q) begin
      rgb_d = mode2_q ? pal_c : direct_c;
    end
    hs3_d = hs2_q;
    vs3_d = vs2_q;
  end

  // CPU read port: in-range reads return stored data, others read as zero
  always_comb begin
    in_range_c = (data_address[31:AW] == '0);
    cpu_idx_c  = data_address[AW-1:0];
    dout_d     = dout_q;
    valid_d    = data_oe;
    if (data_oe) begin
      dout_d = in_range_c ? vram_mem[cpu_idx_c] : 8'h00;
    end
  end

  // Palette write port
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      palette_d[i] = palette_q[i];
    end
    if (palette_we) begin
      palette_d[palette_index] = palette_din;
    end
  end

  // VRAM storage: not reset, out-of-range writes dropped
  always_ff @(posedge clk) begin
    if (data_we && in_range_c) begin
      vram_mem[cpu_idx_c] <= data_din;
    end
  end

  // State registers; reset restarts the frame at (0,0) with the grey ramp
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_h_q <= '0;
      count_v_q <= '0;
      off_h_s_q <= '0;
      off_v_s_q <= '0;
      vblank_q  <= 1'b0;
      frame_q   <= '0;
      addr1_q   <= '0;
      active1_q <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      cell2_q   <= '0;
      mode2_q   <= 1'b0;
      active2_q <= 1'b0;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      rgb_q     <= '0;
      hs3_q     <= 1'b1;
      vs3_q     <= 1'b1;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        palette_q[i] <= {4'(i), 4'(i), 4'(i)};
      end
    end else begin
      count_h_q <= count_h_d;
      count_v_q <= count_v_d;
      off_h_s_q <= off_h_s_d;
      off_v_s_q <= off_v_s_d;
      vblank_q  <= vblank_d;
      frame_q   <= frame_d;
      addr1_q   <= addr1_d;
      active1_q <= active1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      cell2_q   <= cell2_d;
      mode2_q   <= mode2_d;
      active2_q <= active2_d;
      hs2_q     <= hs2_d;
      vs2_q     <= vs2_d;
      rgb_q     <= rgb_d;
      hs3_q     <= hs3_d;
      vs3_q     <= vs3_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      for (int i = 0; i < 16; i++) begin
        palette_q[i] <= palette_d[i];
      end
    end
  end

  assign data_length  = 32'(DEPTH);
  assign data_dout    = dout_q;
  assign data_valid   = valid_q;
  assign vblank_start = vblank_q;
  assign frame_count  = frame_q;
  assign vga_hs       = hs3_q;
  assign vga_vs       = vs3_q;
  assign vga_r        = rgb_q[11:8];
  assign vga_g        = rgb_q[7:4];
  assign vga_b        = rgb_q[3:0];

endmodule

// File: tb/tb_vga_vram_scaled.sv
// Bench for vga_vram_scaled with a shrunken raster (80x20 total, 48x12
// visible) and the full 64x64-cell, x16 VRAM geometry.
module tb_vga_vram_scaled;

  localparam int HT    = 80;
  localparam int VT    = 20;
  localparam int HA    = 48;
  localparam int VA    = 12;
  localparam int HSS   = 56;
  localparam int HSE   = 64;
  localparam int VSS   = 14;
  localparam int VSE   = 16;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_length;
  logic [31:0] data_address;
  logic [7:0]  data_din;
  logic        data_we;
  logic        data_oe;
  logic [7:0]  data_dout;
  logic        data_valid;
  logic        palette_we;
  logic [3:0]  palette_index;
  logic [11:0] palette_din;
  logic        mode;
  logic [31:0] offset_h;
  logic [31:0] offset_v;
  logic        vblank_start;
  logic [15:0] frame_count;
  logic        vga_hs;
  logic        vga_vs;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;

  vga_vram_scaled #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_SYNC_START(HSS), .H_SYNC_END(HSE), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
    .SCALE_SHIFT(4), .COLS_BITS(6), .ROWS_BITS(6)
  ) dut (
    .clk(clk), .reset(reset), .data_length(data_length),
    .data_address(data_address), .data_din(data_din), .data_we(data_we),
    .data_oe(data_oe), .data_dout(data_dout), .data_valid(data_valid),
    .palette_we(palette_we), .palette_index(palette_index),
    .palette_din(palette_din), .mode(mode), .offset_h(offset_h),
    .offset_v(offset_v), .vblank_start(vblank_start),
    .frame_count(frame_count), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mh = 0;
  int mv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference raster position (what the DUT counters should hold)
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mh <= 0;
      mv <= 0;
    end else if (mh == HT - 1) begin
      mh <= 0;
      mv <= (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh <= mh + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pixel scoreboard: expected colour due three clocks after the raster point
  typedef struct {
    int          due;
    logic [11:0] rgb;
    string       name;
  } pix_t;
  pix_t pix_q[$];

  always @(negedge clk) begin
    while (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      check(pix_q[0].name, 32'({vga_r, vga_g, vga_b}), 32'(pix_q[0].rgb));
      void'(pix_q.pop_front());
    end
  end

  // CPU read scoreboard: one expected byte per issued read
  logic [7:0] cpu_q[$];

  always @(negedge clk) begin
    if (data_valid) begin
      if (cpu_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cpu_read: data_valid without request, dout=0x%0h", data_dout);
      end else begin
        check("cpu_read", 32'(data_dout), 32'(cpu_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic       we;
    logic       oe;
    int         addr;
    logic [7:0] din;
    logic [7:0] exp;
  } cpu_vec_t;
  cpu_vec_t vecs[15];

  task automatic wait_hv(input int h, input int v);
    int n = 0;
    while (!(mh == h && mv == v)) begin
      @(negedge clk);
      n++;
      if (n > 2 * FRAME + 4) begin
        checks++;
        errors++;
        $display("FAIL wait_hv: timeout at h=%0d v=%0d, required h=%0d v=%0d", mh, mv, h, v);
        return;
      end
    end
  endtask

  task automatic expect_run(input int v, input int h0, input int n,
                            input logic [11:0] rgb, input string name);
    wait_hv(h0, v);
    for (int i = 0; i < n; i++) begin
      pix_t p;
      p.due  = cyc + 3;
      p.rgb  = rgb;
      p.name = $sformatf("%s v=%0d h=%0d", name, v, h0 + i);
      pix_q.push_back(p);
      if (i < n - 1) @(negedge clk);
    end
  endtask

  task automatic cpu_write(input int addr, input logic [7:0] din);
    data_address = 32'(addr);
    data_din     = din;
    data_we      = 1'b1;
    @(negedge clk);
    data_we      = 1'b0;
  endtask

  task automatic pal_write(input logic [3:0] idx, input logic [11:0] val);
    palette_index = idx;
    palette_din   = val;
    palette_we    = 1'b1;
    @(negedge clk);
    palette_we    = 1'b0;
  endtask

  initial begin
    int hs_low;
    int vs_low;
    int vb_n;
    int vb_first;
    int vb_second;

    reset = 1'b1;
    data_address = '0; data_din = '0; data_we = 1'b0; data_oe = 1'b0;
    palette_we = 1'b0; palette_index = '0; palette_din = '0;
    mode = 1'b0; offset_h = '0; offset_v = '0;

    //           we    oe    addr   din    exp
    vecs[0]  = '{1'b1, 1'b0, 0,     8'hE0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 1,     8'h03, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 63,    8'h1C, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 4095,  8'h7C, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 4096,  8'hAA, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, -1,    8'hBB, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 5,     8'h11, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 1,     8'h00, 8'h03};
    vecs[8]  = '{1'b0, 1'b1, 4096,  8'h00, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, -1,    8'h00, 8'h00};
    vecs[10] = '{1'b0, 1'b1, 0,     8'h00, 8'hE0};
    vecs[11] = '{1'b0, 1'b1, 4095,  8'h00, 8'h7C};
    vecs[12] = '{1'b1, 1'b1, 5,     8'h22, 8'h11};
    vecs[13] = '{1'b0, 1'b1, 5,     8'h00, 8'h22};
    vecs[14] = '{1'b0, 1'b1, 63,    8'h00, 8'h1C};

    repeat (3) @(negedge clk);

    // Reset state
    check("rst_hs", 32'(vga_hs), 32'd1);
    check("rst_vs", 32'(vga_vs), 32'd1);
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_vblank", 32'(vblank_start), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_dout", 32'(data_dout), 32'd0);
    check("data_length", data_length, 32'd4096);

    // Timing over two full frames from reset release
    reset = 1'b0;
    hs_low = 0; vs_low = 0; vb_n = 0; vb_first = -1; vb_second = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (!vga_hs) hs_low++;
      if (!vga_vs) vs_low++;
      if (vblank_start) begin
        vb_n++;
        if (vb_n == 1) vb_first = i;
        else if (vb_n == 2) vb_second = i;
      end
    end
    check("hs_low_cycles", 32'(hs_low), 32'(2 * VT * (HSE - HSS)));
    check("vs_low_cycles", 32'(vs_low), 32'(2 * HT * (VSE - VSS)));
    check("vblank_pulses", 32'(vb_n), 32'd2);
    check("vblank_first", 32'(vb_first), 32'(VA * HT));
    check("vblank_period", 32'(vb_second - vb_first), 32'(FRAME));
    check("frame_count_2", 32'(frame_count), 32'd2);

    // CPU port vectors
    for (int i = 0; i < 15; i++) begin
      data_we      = vecs[i].we;
      data_oe      = vecs[i].oe;
      data_address = 32'(vecs[i].addr);
      data_din     = vecs[i].din;
      if (vecs[i].oe) cpu_q.push_back(vecs[i].exp);
      @(negedge clk);
    end
    data_we = 1'b0;
    data_oe = 1'b0;
    @(negedge clk);
    check("cpu_valid_drop", 32'(data_valid), 32'd0);
    check("cpu_pending", 32'(cpu_q.size()), 32'd0);

    // Scan, mode 0, no scroll
    expect_run(0, 0, 16, 12'hF00, "scan_cell0");
    expect_run(0, 16, 16, 12'h00F, "scan_cell1");
    expect_run(0, HA, 2, 12'h000, "scan_blank");

    // Scroll latched only at vblank
    wait_hv(0, 2);
    offset_h = 32'd16;
    expect_run(3, 0, 1, 12'hF00, "scroll_same_frame");
    expect_run(0, 0, 16, 12'h00F, "scroll_p16");
    wait_hv(0, 2);
    offset_h = 32'(-16);
    expect_run(3, 0, 1, 12'h00F, "scroll_hold");
    expect_run(0, 0, 16, 12'h0F0, "scroll_m16_cell63");
    expect_run(0, 16, 16, 12'hF00, "scroll_m16_cell0");

    // Palette mode
    wait_hv(0, 2);
    offset_h = 32'd0;
    mode = 1'b1;
    cpu_write(0, 8'h05);
    expect_run(0, 0, 16, 12'h555, "pal_ramp5");
    expect_run(0, 16, 16, 12'h333, "pal_ramp3");
    wait_hv(0, 2);
    pal_write(4'd5, 12'h123);
    expect_run(0, 0, 16, 12'h123, "pal_written");

    // Asynchronous reset mid-line
    wait_hv(30, 5);
    check("pre_reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'h333);
    reset = 1'b1;
    #1;
    check("async_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("async_rst_hs", 32'(vga_hs), 32'd1);
    check("async_rst_vs", 32'(vga_vs), 32'd1);
    check("async_rst_frame_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_run(0, 0, 16, 12'h555, "post_reset_cell0");
    expect_run(0, 16, 16, 12'h333, "post_reset_cell1");

    repeat (6) @(negedge clk);
    check("pix_pending", 32'(pix_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
